// File: rtl/soc_pkg.sv
// soc_pkg: shared state encoding and default width for the serial subtractor
package soc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  localparam int SUB_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/fullsubtractor.sv
// fullsubtractor: combinational 1-bit full subtractor cell
module fullsubtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with start/done handshakes; SERIAL_SUB_OVF_EN adds signed overflow
module serial_subtractor
  import soc_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  sub_state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0] cnt;
  logic bin, d, bout, last, accept;
  fullsubtractor u_fs (.x(a_sh[0]), .y(b_sh[0]), .bin(bin), .d(d), .bout(bout));
  assign last   = cnt == CW'(WIDTH - 1);
  assign accept = state == IDLE && start_valid;
  assign diff   = res;
  assign borrow = bin;
  always_comb begin
    state_nx    = state;
    start_ready = state == IDLE;
    done_valid  = state == DONE;
    unique case (state)
      IDLE:    state_nx = start_valid ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = done_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      bin   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        cnt  <= '0;
        bin  <= 1'b0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        res  <= {d, res[WIDTH-1:1]};
        bin  <= bout;
        cnt  <= last ? cnt : cnt + 1'b1;
      end
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
  // On the final RUN cycle d is the result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_msb    <= a[WIDTH-1];
      b_msb    <= b[WIDTH-1];
      overflow <= 1'b0;
    end else if (state == RUN && last) begin
      overflow <= (a_msb ^ b_msb) & (d ^ a_msb);
    end
  end
`endif
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor that computes diff = a - b one bit per clock, LSB first. It is the sequential counterpart to the combinational adder primitives in the SoC arithmetic library. Operands enter through a valid/ready start handshake, and results leave through a valid/ready done handshake. It is the first multi-cycle arithmetic block in the library and trades latency for a single 1-bit datapath cell.

## Interface
Parameters:
- WIDTH, default 8: operand/result width in bits; legal range is 2 or more.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset; asynchronous assert, active-low.
- start_valid, input, 1: operands on a/b are valid.
- start_ready, output, 1: block can accept operands. High only in IDLE.
- a, input, WIDTH: minuend, sampled on the start handshake.
- b, input, WIDTH: subtrahend, sampled on the start handshake.
- done_valid, output, 1: diff/borrow hold a completed result.
- done_ready, input, 1: consumer accepts the result.
- diff, output, WIDTH: a - b modulo 2^WIDTH.
- borrow, output, 1: final borrow out. It is 1 iff unsigned a < b.

## Operation
- State machine has three states: IDLE, RUN and DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: load a_sh <= a, b_sh <= b, bit counter cnt <= 0, borrow register bin <= 0. Go to RUN.
- RUN, each cycle:
  - The fullsubtractor cell takes x = a_sh[0], y = b_sh[0] and bin.
  - d is shifted into the MSB of the result shift register. a_sh and b_sh shift right by 1.
  - bin <= bout and cnt <= cnt + 1.
  - When cnt == WIDTH-1, go to DONE.
- DONE:
  - done_valid = 1. diff shows the result register and borrow shows bin.
  - On done_ready, go to IDLE.
  - Outputs stay stable while done_ready = 0.
- start_valid is ignored outside IDLE. No operand is buffered, and there is no IDLE bypass from DONE.
- done_ready is ignored outside DONE.
- cnt width is $clog2(WIDTH). Its compare with WIDTH-1 is exact, with no wrap-around past WIDTH-1.
- Arithmetic is unsigned modulo 2^WIDTH. Borrow semantics: 0 - 1 gives diff = all ones and borrow = 1.

## Timing
- Reset values while rst_n = 0:
  - State is IDLE, so start_ready = 1.
  - done_valid = 0, diff = 0, borrow = 0.
  - All internal registers are 0.
- Latency: if the start handshake completes at edge N, done_valid rises after edge N+WIDTH.
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH RUN cycles, done handshake, return to IDLE).
- Reset mid-operation aborts immediately, in RUN or DONE. No partial result is ever presented, and the next operation after release is exact.
- start_valid may deassert after the handshake without effect.
- diff and borrow are registered outputs. Their values outside DONE are don't-care for checkers.

## Configuration
Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port `overflow` (output, 1 bit): signed two's-complement overflow.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), registered at the RUN to DONE transition.
  - Valid in DONE and reset to 0.
  - The block keeps a captured copy of the operand MSBs for this.
- Undefined: the port, the logic and the captured MSB bits are absent. Behaviour is otherwise identical.

## Structure
- soc_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - Constant SUB_DEFAULT_WIDTH = 8.
- Sub-module fullsubtractor:
  - Purely combinational 1-bit cell with ports x, y, bin, d, bout.
  - d = x ^ y ^ bin.
  - bout = (~x & y) | (~(x ^ y) & bin).
  - Instantiated once in serial_subtractor and has its own exhaustive 8-vector bench.

## Test plan
All scenarios use WIDTH = 8.
- 10 - 3: start with a = 8'd10, b = 8'd3 → diff = 8'd7, borrow = 0, done_valid exactly 8 cycles after the accept edge.
- 3 - 10: a = 8'd3, b = 8'd10 → diff = 8'hF9, borrow = 1.
- Edge operands:
  - 8'h00 - 8'h00 → 8'h00, borrow 0.
  - 8'hFF - 8'hFF → 8'h00, borrow 0.
  - 8'h00 - 8'h01 → 8'hFF, borrow 1.
- Backpressure: hold done_ready = 0 for 5 cycles in DONE while pulsing start_valid with new operands → diff/borrow stable, start_ready = 0, new operands never taken. Raising done_ready returns the block to IDLE on the next edge.
- Reset mid-run: deassert rst_n during the 4th RUN cycle → outputs return to reset values asynchronously. After release, 8'd200 - 8'd55 gives diff = 8'd145, borrow = 0.
- With SERIAL_SUB_OVF_EN:
  - 8'h80 - 8'h01 → diff = 8'h7F, overflow = 1.
  - 8'h7F - 8'h01 → diff = 8'h7E, overflow = 0.
  - 8'h7F - 8'hFF → diff = 8'h80, overflow = 1.
